// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder behind the execute stage's memory port.
// Serves word/half/byte loads and stores from an internal byte-lane RAM after
// LATENCY wait states. Loads come back right-justified, zero-extended, with a
// one-cycle rvalid pulse. busy is a combinational stall back to the pipeline.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN adds the misalign output and
// suppresses accesses whose address low bits disagree with the lane mask.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   memAddr   request byte address
//   memData   store data, lane-aligned
//   readWr    load request
//   writeWr   store request (wins when both are high)
//   rmask     load lane mask
//   wmask     store lane mask
//   rdata     load result (registered, holds between responses)
//   rvalid    one-cycle load-response pulse (registered)
//   busy      combinational stall
//   misalign  one-cycle misaligned-access pulse (MEM_ALIGN_CHECK_EN only)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [31:0] memData,
  input  logic        readWr,
  input  logic        writeWr,
  input  logic [3:0]  rmask,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = 3;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              req_c;
  logic              accept_c;
  logic              access_c;
  logic [CW-1:0]     cnt;

  logic [31:0]       lat_addr;
  logic [31:0]       lat_data;
  logic [3:0]        lat_rmask;
  logic [3:0]        lat_wmask;
  logic              lat_wr;

  logic [31:0]       off_c;
  logic              in_range_c;
  logic [AW-1:0]     idx_c;
  logic [31:0]       word_c;
  logic [31:0]       lane_c;
  logic [4:0]        sh_c;
  logic [31:0]       load_c;
  logic              mis_c;

  logic [3:0][7:0]   mem [DEPTH_WORDS];

  // Index of the lowest set bit of a lane mask (3 when the mask is empty).
  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign req_c = readWr | writeWr;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, accept/access strobes and the stall.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    access_c  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        busy = req_c;
        if (req_c) begin
          accept_c  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          access_c  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Back-to-back: a request present in RESP is accepted immediately.
        busy      = req_c;
        accept_c  = req_c;
        state_nxt = req_c ? WAIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address decode on the latched request.
  assign off_c      = lat_addr - ADDR_BASE;
  assign in_range_c = {1'b0, off_c} < SPAN;
  assign idx_c      = off_c[AW+1:2];

  // Load path: mask lanes, then right-justify on the lowest selected lane.
  assign word_c = mem[idx_c];
  assign lane_c = {{8{lat_rmask[3]}}, {8{lat_rmask[2]}},
                   {8{lat_rmask[1]}}, {8{lat_rmask[0]}}};
  assign sh_c   = {low_lane(lat_rmask), 3'b000};
  assign load_c = (word_c & lane_c) >> sh_c;

`ifdef MEM_ALIGN_CHECK_EN
  logic [3:0] act_mask_c;
  assign act_mask_c = lat_wr ? lat_wmask : lat_rmask;
  assign mis_c      = (act_mask_c != 4'b0000) &&
                      (lat_addr[1:0] != low_lane(act_mask_c));
`else
  assign mis_c = 1'b0;
`endif

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_rmask <= '0;
      lat_wmask <= '0;
      lat_wr    <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
    end else begin
      rvalid <= access_c & ~lat_wr;
      if (accept_c) begin
        lat_addr  <= memAddr;
        lat_data  <= memData;
        lat_rmask <= rmask;
        lat_wmask <= wmask;
        lat_wr    <= writeWr;
        cnt       <= CW'(LATENCY);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (access_c && !lat_wr) begin
        rdata <= (in_range_c && !mis_c) ? load_c : 32'h0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Misalign pulse at response timing for both loads and stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign <= 1'b0;
    else      misalign <= access_c & mis_c;
  end
`endif

  // Byte-lane RAM write; contents are not reset.
  always_ff @(posedge clk) begin
    if (access_c && lat_wr && in_range_c && !mis_c) begin
      for (int k = 0; k < 4; k++) begin
        if (lat_wmask[k]) mem[idx_c][k] <= lat_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected responses
// (data, misalign flag, response cycle) and a negedge monitor pops and compares.
module tb_dmem_responder;

  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    logic        rv;
    logic [31:0] data;
    logic        mis;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        readWr;
  logic        writeWr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        misalign_s;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_rdata = 32'h0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .ADDR_BASE  (32'h0000_0000)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .memAddr (memAddr),
    .memData (memData),
    .readWr  (readWr),
    .writeWr (writeWr),
    .rmask   (rmask),
    .wmask   (wmask),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign(misalign_s)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign misalign_s = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop on every response, otherwise rdata must hold.
  always @(negedge clk) begin
    if (!rst) begin
      last_rdata = 32'h0;
    end else if (rvalid || misalign_s) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: rvalid=%b misalign=%b rdata=%h with empty scoreboard (cycle %0d)",
                 rvalid, misalign_s, rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_rvalid", 32'(rvalid), 32'(mon_e.rv));
        check("resp_misalign", 32'(misalign_s), 32'(mon_e.mis));
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.rv) begin
          check("resp_rdata", rdata, mon_e.data);
          last_rdata = mon_e.data;
        end else begin
          check("rdata_hold", rdata, last_rdata);
        end
      end
    end else begin
      check("rdata_hold", rdata, last_rdata);
    end
  end

  // Issue one request from just after a posedge; returns in its RESP cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] rm, input logic [3:0] wm,
                        input logic mis, input logic [31:0] exp_data);
    exp_t e;
    memAddr = a;
    memData = d;
    rmask   = rm;
    wmask   = wm;
    readWr  = rd;
    writeWr = wr;
    #1;
    check("busy_req", 32'(busy), 32'd1);
    e.rv   = !wr;
    e.data = exp_data;
    e.mis  = mis;
    e.cyc  = cyc + int'(LAT) + 2;
    if (!wr || mis) sb.push_back(e);
    @(posedge clk); #1;
    readWr  = 1'b0;
    writeWr = 1'b0;
    for (int i = 0; i <= int'(LAT); i++) begin
      check("busy_wait", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    check("busy_resp", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    memAddr = 32'h0;
    memData = 32'h0;
    readWr  = 1'b0;
    writeWr = 1'b0;
    rmask   = 4'h0;
    wmask   = 4'h0;
    #1 rst = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_misalign", 32'(misalign_s), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // Full-word store then load.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'h0, 4'hF, 1'b0, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 1'b0, 32'hDEADBEEF);      idle(1);

    // Byte-lane merge and right-justified partial loads.
    do_req(1'b0, 1'b1, 32'h20, 32'h11223344, 4'h0, 4'hF, 1'b0, 32'h0);      idle(1);
    do_req(1'b0, 1'b1, 32'h21, 32'h0000AA00, 4'h0, 4'h2, 1'b0, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 4'h0, 1'b0, 32'h1122AA44);      idle(1);
    do_req(1'b1, 1'b0, 32'h21, 32'h0, 4'h2, 4'h0, 1'b0, 32'h000000AA);      idle(1);
    do_req(1'b1, 1'b0, 32'h22, 32'h0, 4'hC, 4'h0, 1'b0, 32'h00001122);      idle(1);
    do_req(1'b1, 1'b0, 32'h23, 32'h0, 4'h8, 4'h0, 1'b0, 32'h00000011);      idle(1);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'h0, 1'b0, 32'h00000000);      idle(1);

    // Both enables high behaves as a store (no rvalid expected).
    do_req(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 4'hF, 1'b0, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 4'h0, 1'b0, 32'hA5A5A5A5);      idle(1);

    // Back-to-back loads: second presented in the RESP cycle of the first.
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 1'b0, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 4'h0, 1'b0, 32'h1122AA44);      idle(1);

    // Range boundary: last word in range, first word out of range.
    do_req(1'b0, 1'b1, 32'h0, 32'h01234567, 4'h0, 4'hF, 1'b0, 32'h0);       idle(1);
    do_req(1'b0, 1'b1, 32'hFFC, 32'h89ABCDEF, 4'h0, 4'hF, 1'b0, 32'h0);     idle(1);
    do_req(1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF, 4'h0, 1'b0, 32'h89ABCDEF);     idle(1);
    do_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 4'h0, 1'b0, 32'h00000000);    idle(1);
    do_req(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'h0, 4'hF, 1'b0, 32'h0);    idle(1);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 4'h0, 1'b0, 32'h01234567);       idle(1);

    // Reset during WAIT abandons an in-flight store.
    do_req(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'h0, 4'hF, 1'b0, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 4'h0, 1'b0, 32'hCAFEF00D);      idle(1);
    memAddr = 32'h30;
    memData = 32'h0BADBEEF;
    wmask   = 4'hF;
    writeWr = 1'b1;
    #1 check("busy_req_abandon", 32'(busy), 32'd1);
    @(posedge clk); #1;
    writeWr = 1'b0;
    check("busy_wait_abandon", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("busy_after_reset", 32'(busy), 32'd0);
    check("rvalid_after_reset", 32'(rvalid), 32'd0);
    check("rdata_after_reset", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(3);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 4'h0, 1'b0, 32'hCAFEF00D);      idle(1);

`ifdef MEM_ALIGN_CHECK_EN
    // Alignment checking: misaligned load/store suppressed, aligned half written.
    do_req(1'b1, 1'b0, 32'h12, 32'h0, 4'hF, 4'h0, 1'b1, 32'h00000000);      idle(1);
    do_req(1'b0, 1'b1, 32'h12, 32'h55660000, 4'h0, 4'hC, 1'b0, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 1'b0, 32'h5566BEEF);      idle(1);
    do_req(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'h0, 4'hF, 1'b1, 32'h0);      idle(1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'h0, 1'b0, 32'h5566BEEF);      idle(1);
`endif

    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
